// File: rtl/accel_sequencer.sv
// Layer-level controller stepping one conv/act/pool accelerator through a multi-filter pass.
// Define SEQ_DRAIN_WDT_EN to enable the drain watchdog (sets err and skips a stuck filter).
module accel_sequencer #(
    parameter int unsigned n         = 10,
    parameter int unsigned k         = 3,
    parameter int unsigned p         = 2,
    parameter int unsigned NF        = 4,
    parameter int unsigned N         = 16,
    parameter int unsigned AW        = 10,
    parameter int unsigned DRAIN_MAX = 64
) (
    input  logic             clk,
    input  logic             global_rst,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             act_rd,
    output logic [AW-1:0]    act_addr,
    input  logic [N-1:0]     act_data,
    output logic             w_rd,
    output logic [7:0]       w_addr,
    input  logic [k*k*N-1:0] w_data,
    output logic             acc_rst,
    output logic             acc_ce,
    output logic [N-1:0]     acc_activation,
    output logic [k*k*N-1:0] acc_weights,
    input  logic [N-1:0]     acc_data_out,
    input  logic             acc_valid_op,
    input  logic             acc_end_op,
    output logic             out_wr,
    output logic [AW-1:0]    out_addr,
    output logic [N-1:0]     out_data
);

    localparam int unsigned PO  = (n - k + 1) / p;
    localparam int unsigned NPO = PO * PO;
    localparam int unsigned NN  = n * n;
    localparam int unsigned IW  = (NN > 1) ? $clog2(NN) : 1;
    localparam int unsigned OW  = $clog2(NPO + 1);

    if (NF < 1 || NF > 256) begin : g_bad_nf
        $error("accel_sequencer: NF must be 1..256");
    end
    if (DRAIN_MAX < 1) begin : g_bad_drain
        $error("accel_sequencer: DRAIN_MAX must be at least 1");
    end

    typedef enum logic [2:0] {
        StIdle, StLoadW, StLatchW, StClr, StStream, StDrain, StNext, StDone
    } state_t;

    state_t         state_q;
    logic [7:0]     f_q;
    logic [IW-1:0]  icnt_q;
    logic [OW-1:0]  ocnt_q;
    logic           clr_second_q;
    logic           rd_q;
    logic           abort_hit;
    logic           in_capture;
    logic           drain_exit;

`ifdef SEQ_DRAIN_WDT_EN
    localparam int unsigned DW = $clog2(DRAIN_MAX + 1);
    logic [DW-1:0]  dcnt_q;
`else
    assign err = 1'b0;
`endif

    // DONE always finishes its pulse, so abort is only honoured before it.
    assign abort_hit  = abort && (state_q != StIdle) && (state_q != StDone);
    assign in_capture = (state_q == StStream) || (state_q == StDrain);
    assign drain_exit = acc_end_op && (ocnt_q == OW'(NPO));

    assign out_wr   = acc_valid_op && in_capture && (ocnt_q < OW'(NPO)) && !abort_hit;
    assign out_addr = AW'(f_q) * AW'(NPO) + AW'(ocnt_q);
    assign out_data = acc_data_out;

    // Read data returns one cycle after act_rd, so ce follows the delayed strobe.
    assign acc_ce         = (rd_q || (state_q == StDrain)) && !abort_hit;
    assign acc_activation = rd_q ? act_data : '0;
    assign act_addr       = AW'(icnt_q);
    assign w_addr         = f_q;

    always_ff @(posedge clk) begin
        if (!global_rst) begin
            state_q      <= StIdle;
            f_q          <= '0;
            icnt_q       <= '0;
            ocnt_q       <= '0;
            clr_second_q <= 1'b0;
            rd_q         <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            act_rd       <= 1'b0;
            w_rd         <= 1'b0;
            acc_rst      <= 1'b1;
            acc_weights  <= '0;
`ifdef SEQ_DRAIN_WDT_EN
            dcnt_q       <= '0;
            err          <= 1'b0;
`endif
        end else begin
            done    <= 1'b0;
            w_rd    <= 1'b0;
            act_rd  <= 1'b0;
            acc_rst <= 1'b0;
            rd_q    <= act_rd && !abort_hit;
            if (out_wr) begin
                ocnt_q <= ocnt_q + 1'b1;
            end
            if (abort_hit) begin
                state_q <= StIdle;
                busy    <= 1'b0;
                acc_rst <= 1'b1;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start) begin
                            state_q <= StLoadW;
                            f_q     <= '0;
                            busy    <= 1'b1;
                            w_rd    <= 1'b1;
`ifdef SEQ_DRAIN_WDT_EN
                            err     <= 1'b0;
`endif
                        end
                    end
                    StLoadW: begin
                        state_q <= StLatchW;
                    end
                    StLatchW: begin
                        acc_weights  <= w_data;
                        acc_rst      <= 1'b1;
                        clr_second_q <= 1'b0;
                        state_q      <= StClr;
                    end
                    StClr: begin
                        icnt_q       <= '0;
                        ocnt_q       <= '0;
                        clr_second_q <= 1'b1;
`ifdef SEQ_DRAIN_WDT_EN
                        dcnt_q       <= '0;
`endif
                        if (clr_second_q) begin
                            state_q <= StStream;
                            act_rd  <= 1'b1;
                        end else begin
                            acc_rst <= 1'b1;
                        end
                    end
                    StStream: begin
                        icnt_q <= icnt_q + 1'b1;
                        if (icnt_q == IW'(NN - 1)) begin
                            state_q <= StDrain;
                        end else begin
                            act_rd <= 1'b1;
                        end
                    end
                    StDrain: begin
`ifdef SEQ_DRAIN_WDT_EN
                        dcnt_q <= dcnt_q + 1'b1;
                        if (drain_exit) begin
                            state_q <= StNext;
                        end else if (dcnt_q == DW'(DRAIN_MAX - 1)) begin
                            err     <= 1'b1;
                            state_q <= StNext;
                        end
`else
                        if (drain_exit) begin
                            state_q <= StNext;
                        end
`endif
                    end
                    StNext: begin
                        f_q <= f_q + 1'b1;
                        if (f_q == 8'(NF - 1)) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                        end else begin
                            state_q <= StLoadW;
                            w_rd    <= 1'b1;
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_accel_sequencer.sv
// Directed bench for accel_sequencer with behavioural memories and accelerator model.
module tb_accel_sequencer;

    localparam int N   = 16;
    localparam int K   = 3;
    localparam int AW  = 10;
    localparam int NPO = 16;
    localparam int NN  = 100;

    logic             clk = 1'b0;
    logic             global_rst;
    logic             start;
    logic             abort;
    logic             busy, done, err;
    logic             act_rd;
    logic [AW-1:0]    act_addr;
    logic [N-1:0]     act_data = '0;
    logic             w_rd;
    logic [7:0]       w_addr;
    logic [K*K*N-1:0] w_data = '0;
    logic             acc_rst, acc_ce;
    logic [N-1:0]     acc_activation;
    logic [K*K*N-1:0] acc_weights;
    logic [N-1:0]     acc_data_out = '0;
    logic             acc_valid_op = 1'b0;
    logic             acc_end_op = 1'b0;
    logic             out_wr;
    logic [AW-1:0]    out_addr;
    logic [N-1:0]     out_data;

    always #5 clk = ~clk;

    accel_sequencer #(
        .n(10), .k(3), .p(2), .NF(4), .N(16), .AW(10), .DRAIN_MAX(64)
    ) dut (
        .clk(clk), .global_rst(global_rst), .start(start), .abort(abort),
        .busy(busy), .done(done), .err(err),
        .act_rd(act_rd), .act_addr(act_addr), .act_data(act_data),
        .w_rd(w_rd), .w_addr(w_addr), .w_data(w_data),
        .acc_rst(acc_rst), .acc_ce(acc_ce), .acc_activation(acc_activation),
        .acc_weights(acc_weights), .acc_data_out(acc_data_out),
        .acc_valid_op(acc_valid_op), .acc_end_op(acc_end_op),
        .out_wr(out_wr), .out_addr(out_addr), .out_data(out_data)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] act_val(input int a);
        return N'(a * 7 + 3);
    endfunction

    function automatic logic [K*K*N-1:0] wvec(input int fi);
        logic [K*K*N-1:0] v;
        for (int i = 0; i < K * K; i++) v[i*N +: N] = N'(32'hA000 + fi * 256 + i * 16);
        return v;
    endfunction

    // Memories: registered read, data one cycle after the strobe.
    always @(posedge clk) begin
        if (act_rd) act_data <= act_val(int'(act_addr));
        if (w_rd) w_data <= wvec(int'(w_addr));
    end

    int cur_f = 0;
    int extra_f = -1;
    int hang_f = -1;
    int m_ce = 0;
    int m_out = 0;
    int stream_err = 0;

    // Accelerator model: checks the ce stream, emits results at ce 50,55,...
    always @(posedge clk) begin : model
        int lim;
        lim = (cur_f == extra_f) ? NPO + 1 : NPO;
        if (acc_rst) begin
            m_ce <= 0;
            m_out <= 0;
            acc_valid_op <= 1'b0;
            acc_end_op <= 1'b0;
        end else begin
            acc_valid_op <= 1'b0;
            if (acc_ce) begin
                m_ce <= m_ce + 1;
                if (m_ce < NN) begin
                    if (acc_activation !== act_val(m_ce)) stream_err <= stream_err + 1;
                end else if (acc_activation !== '0) begin
                    stream_err <= stream_err + 1;
                end
                if (m_out < lim && m_ce + 1 == 50 + 5 * m_out) begin
                    acc_valid_op <= 1'b1;
                    acc_data_out <= acc_weights[N-1:0] + N'(m_out);
                    m_out <= m_out + 1;
                end
            end
            if (m_out >= lim && cur_f != hang_f) acc_end_op <= 1'b1;
        end
    end

    int act_cnt = 0, wr_cnt = 0, done_cnt = 0, wt_err = 0;
    int f_act = 0, f_wr = 0, w_cnt = 0;
    logic prev_busy = 1'b0;

    always @(negedge clk) begin
        if (busy && !prev_busy) w_cnt = 0;
        prev_busy = busy;
        if (done) done_cnt++;
        if (w_rd) begin
            check_eq("w_addr", w_addr, w_cnt);
            w_cnt++;
            cur_f = int'(w_addr);
            f_act = 0;
            f_wr = 0;
        end
        if (act_rd) begin
            check_eq("act_addr", act_addr, f_act);
            f_act++;
            act_cnt++;
        end
        if (acc_ce && acc_weights !== wvec(cur_f)) wt_err++;
        if (out_wr) begin
            check_eq("out_addr", out_addr, cur_f * NPO + f_wr);
            check_eq("out_data", out_data, 32'hA000 + cur_f * 256 + f_wr);
            check_eq("wr_in_range", f_wr < NPO, 1);
            f_wr++;
            wr_cnt++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_pass();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int i;
        i = 0;
        while (busy && i < 3000) begin
            tick();
            i++;
        end
        check_eq(tag, busy, 0);
    endtask

    task automatic run_full(input string tag);
        int a0, w0, d0, e0, s0;
        a0 = act_cnt; w0 = wr_cnt; d0 = done_cnt; e0 = wt_err; s0 = stream_err;
        start_pass();
        wait_idle({tag, "_timeout"});
        check_eq({tag, "_act_rd"}, act_cnt - a0, 400);
        check_eq({tag, "_out_wr"}, wr_cnt - w0, 64);
        check_eq({tag, "_done"}, done_cnt - d0, 1);
        check_eq({tag, "_weights"}, wt_err - e0, 0);
        check_eq({tag, "_stream"}, stream_err - s0, 0);
        check_eq({tag, "_w_cnt"}, w_cnt, 4);
    endtask

    initial begin
        #500_000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int i, a0, w0, d0, e0, s0;
        global_rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(posedge clk);
        tick();
        check_eq("rst_acc_rst", acc_rst, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_out_wr", out_wr, 0);
        check_eq("rst_act_rd", act_rd, 0);
        check_eq("rst_w_rd", w_rd, 0);
        check_eq("rst_acc_ce", acc_ce, 0);
        check_eq("rst_err", err, 0);
        global_rst = 1'b1;
        tick();
        check_eq("idle_acc_rst", acc_rst, 0);
        check_eq("idle_busy", busy, 0);

        // Pass 1 with latency checks.
        a0 = act_cnt; w0 = wr_cnt; d0 = done_cnt; e0 = wt_err; s0 = stream_err;
        start_pass();
        check_eq("busy_rise", busy, 1);
        i = 0;
        while (!act_rd && i < 10) begin
            tick();
            i++;
        end
        check_eq("start_to_rd", i, 4);
        wait_idle("p1_timeout");
        check_eq("p1_act_rd", act_cnt - a0, 400);
        check_eq("p1_out_wr", wr_cnt - w0, 64);
        check_eq("p1_done", done_cnt - d0, 1);
        check_eq("p1_weights", wt_err - e0, 0);
        check_eq("p1_stream", stream_err - s0, 0);
        check_eq("p1_w_cnt", w_cnt, 4);
        check_eq("p1_err", err, 0);

        // Start while busy is ignored; abort at the 50th read of filter 1.
        a0 = act_cnt; w0 = wr_cnt; d0 = done_cnt;
        start_pass();
        start = 1'b1;
        i = 0;
        while (!(cur_f == 1 && f_act == 50 && act_rd) && i < 2000) begin
            tick();
            i++;
        end
        start = 1'b0;
        check_eq("abort_reach", f_act, 50);
        abort = 1'b1;
        #1;
        check_eq("abort_ce", acc_ce, 0);
        check_eq("abort_out_wr", out_wr, 0);
        tick();
        abort = 1'b0;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_acc_rst", acc_rst, 1);
        repeat (300) tick();
        check_eq("abort_act_rd", act_cnt - a0, 150);
        check_eq("abort_out_wr_total", wr_cnt - w0, 16);
        check_eq("abort_no_done", done_cnt - d0, 0);
        check_eq("abort_idle", busy, 0);

        run_full("p2");

        // Seventeen results for filter 1: only sixteen may be written.
        extra_f = 1;
        run_full("p3");
        extra_f = -1;

`ifdef SEQ_DRAIN_WDT_EN
        hang_f = 2;
        w0 = wr_cnt; d0 = done_cnt;
        start_pass();
        i = 0;
        while (!(cur_f == 2 && f_act == NN && act_rd) && i < 2000) begin
            tick();
            i++;
        end
        check_eq("wdt_reach", f_act, NN);
        repeat (64) tick();
        check_eq("wdt_early", err, 0);
        tick();
        check_eq("wdt_set", err, 1);
        wait_idle("wdt_timeout");
        check_eq("wdt_done", done_cnt - d0, 1);
        check_eq("wdt_out_wr", wr_cnt - w0, 64);
        check_eq("wdt_sticky", err, 1);
        hang_f = -1;
        start_pass();
        check_eq("wdt_err_clear", err, 0);
        wait_idle("wdt_after_timeout");
`else
        check_eq("err_tied", err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/accel_sequencer.md
# accel_sequencer

Layer-level controller that drives one convolution/activation/pooling accelerator instance through a multi-filter pass over a single input feature map. For each filter it fetches the k×k weight vector, clears the accelerator, streams the n×n activation map from an external feature-map memory, drains the pipeline, and writes every pooled result to an output memory at a filter-major address. It sits between the feature/weight/output memories and the accelerator, and is the only block that drives the accelerator's `ce`, reset, activation and weight inputs.

## Interface
- `n`, 10: input map side length.
- `k`, 3: convolution window side.
- `p`, 2: pooling window side.
- `NF`, 4: filters per pass (1..256).
- `N`, 16: datapath width.
- `AW`, 10: activation and output memory address width.
- `DRAIN_MAX`, 64: drain watchdog limit in cycles.

Derived:
- `PO = (n-k+1)/p`: pooled side length.
- `NPO = PO*PO`: 16 at defaults.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `global_rst`  in  1  synchronous, active-low reset.
- `start`  in  1  begin a pass; sampled in IDLE only.
- `abort`  in  1  cancel the pass; sampled in any non-IDLE state.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a pass completes.
- `err`  out  1  sticky drain-timeout flag; cleared on `start`.
- `act_rd`  out  1  activation memory read strobe.
- `act_addr`  out  AW  activation read address.
- `act_data`  in  N  activation read data; valid 1 cycle after `act_rd`.
- `w_rd`  out  1  weight memory read strobe.
- `w_addr`  out  8  filter index.
- `w_data`  in  k*k*N  weight vector; valid 1 cycle after `w_rd`.
- `acc_rst`  out  1  accelerator reset, active-high.
- `acc_ce`  out  1  accelerator clock enable.
- `acc_activation`  out  N  accelerator activation input.
- `acc_weights`  out  k*k*N  latched weight vector.
- `acc_data_out`  in  N  accelerator pooled result.
- `acc_valid_op`  in  1  pooled result valid.
- `acc_end_op`  in  1  accelerator end-of-map flag.
- `out_wr`  out  1  output memory write strobe.
- `out_addr`  out  AW  output write address, `f*NPO + ocnt`.
- `out_data`  out  N  output write data.

## Operation
- Registers:
  - `f`: filter index.
  - `icnt`: input counter, 0..n*n-1.
  - `ocnt`: output counter, 0..NPO.
  - `dcnt`: drain cycle counter.
- FSM states: IDLE, LOAD_W, LATCH_W, CLR, STREAM, DRAIN, NEXT, DONE.
- IDLE → LOAD_W on `start`: clear `f`; clear `err`.
- LOAD_W, one cycle: `w_rd=1`, `w_addr=f`.
- LATCH_W, one cycle: capture `w_data` into `acc_weights`; the register is held constant until the next LATCH_W.
- CLR, two cycles: `acc_rst=1`, `acc_ce=0`; clear `icnt`, `ocnt`, `dcnt`.
- STREAM:
  - Each cycle, `act_rd=1` and `act_addr=icnt`; `icnt` increments.
  - After the read with `icnt=n*n-1`, go to DRAIN.
- Delayed stream: `acc_ce` and `acc_activation` are `act_rd` and `act_data` delayed one cycle. The accelerator sees exactly n*n consecutive `ce` cycles carrying real data.
- DRAIN:
  - `acc_ce=1` with `acc_activation=0`.
  - Leave to NEXT on the first cycle with `acc_end_op=1` and `ocnt==NPO`.
- Output capture, in STREAM and DRAIN:
  - Each `acc_valid_op` with `ocnt<NPO` writes `out_data=acc_data_out` at `f*NPO+ocnt`, then increments `ocnt`.
  - A `valid_op` with `ocnt==NPO` is ignored.
- NEXT: increment `f`. If the old `f` was NF-1, go to DONE; otherwise go to LOAD_W.
- DONE: `done=1` for one cycle, then IDLE.
- Abort:
  - `abort` in any non-IDLE state goes to IDLE on the next edge.
  - `acc_rst=1` for that cycle; `acc_ce=0` and `out_wr=0` from the abort cycle on.
  - No `done` pulse.
- Simultaneous `abort` and `done`: `abort` wins only if sampled before DONE; DONE always completes its pulse.
- `start` while busy is ignored.

## Timing
- Reset (`global_rst=0`), all outputs are 0 except `acc_rst=1` held for the reset duration. State is IDLE.
- `start` to first `act_rd`: 4 cycles (LOAD_W, LATCH_W, CLR, CLR).
- `act_rd` to `acc_ce`: 1 cycle.
- `acc_valid_op` to `out_wr`: combinational, same cycle. `out_*` are valid only while `out_wr=1`.
- Per-filter cycle count: 4 + n*n + drain + 1 (NEXT).
- `done` asserts exactly one cycle after NEXT of the last filter.

## Configuration
- Macro: `SEQ_DRAIN_WDT_EN`.
- Defined:
  - `dcnt` counts DRAIN cycles.
  - When `dcnt` reaches DRAIN_MAX, set `err=1`, skip the remaining outputs of that filter, and go to NEXT.
  - The pass still completes with `done`.
- Undefined:
  - DRAIN waits indefinitely.
  - `dcnt` logic is removed and `err` is tied to 0.

## Test plan
- Reset: `global_rst=0` for 3 cycles → `acc_rst=1`, `busy=0`, `done=0`, `out_wr=0`. Release → IDLE with `acc_rst=0`.
- Single pass, NF=4, n=10, k=3, p=2, with a behavioural accelerator model:
  - `busy` rises 1 cycle after `start`.
  - 400 `act_rd` pulses total, 100 per filter.
  - 64 `out_wr` writes to addresses 0..63, in order within each filter.
  - One `done` pulse.
- Weight handling: `w_data` differs per filter → `acc_weights` equals word f throughout filter f's STREAM and DRAIN. `w_addr` sequence is 0,1,2,3.
- Abort at the 50th `act_rd` of filter 1:
  - Next cycle `busy=0`, `acc_rst=1`, no further `out_wr`, no `done`.
  - A subsequent `start` runs a full pass.
- Extra `valid_op`: the model emits 17 valid outputs for one filter → exactly 16 writes, no address overflow into the next filter's range.
- Watchdog (`SEQ_DRAIN_WDT_EN`, DRAIN_MAX=64): the model never asserts `end_op` for filter 2 → `err=1` after 64 DRAIN cycles, filter 3 proceeds, `done` pulses, and `err` clears on the next `start`.
